// File: rtl/prog_mem_responder_pkg.sv
// Shared defaults, state encoding and helpers for the program-memory responder.
// PROG_MEM_ALIGN_CHECK_EN (left undefined by default) enables misaligned-fetch error responses.
package prog_mem_responder_pkg;

    localparam int PMR_MEM_ADDR_WIDTH = 10;
    localparam int PMR_DATA_WIDTH     = 32;
    localparam int PMR_CNT_WIDTH      = 4;

    typedef enum logic {
        PMR_IDLE  = 1'b0,
        PMR_STALL = 1'b1
    } pmr_state_e;

    function automatic logic pmr_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/prog_mem_responder_if.sv
// Instruction-fetch request/grant/response port plus the boot/bench load port.
// master = core/loader side, slave = responder side.
interface prog_mem_responder_if
    import prog_mem_responder_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = PMR_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH     = PMR_DATA_WIDTH
);
    logic                      req_i;
    logic [MEM_ADDR_WIDTH-1:0] addr_i;
    logic                      gnt_o;
    logic                      rvalid_o;
    logic [DATA_WIDTH-1:0]     rdata_o;
    logic                      err_o;
    logic                      we_i;
    logic [MEM_ADDR_WIDTH-1:0] waddr_i;
    logic [DATA_WIDTH-1:0]     wdata_i;

    modport master (
        output req_i, addr_i, we_i, waddr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, waddr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/prog_mem_responder_array.sv
// prog_mem_array: word storage with one registered read port and one write port.
// Read data appears one cycle after i_re; a same-edge write to the read word returns the old data.
module prog_mem_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage has no reset so boot contents survive a core reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/prog_mem_responder.sv
// Fetch responder: grant after WAIT_CYCLES wait states, word returned one cycle after the grant edge.
// Dropping req_i during the wait countdown aborts it. PROG_MEM_ALIGN_CHECK_EN flags misaligned fetches.
module prog_mem_responder
    import prog_mem_responder_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = PMR_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH     = PMR_DATA_WIDTH,
    parameter int WAIT_CYCLES    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prog_mem_responder_if.slave  bus
);
    localparam int WORD_AW = MEM_ADDR_WIDTH - 2;
    localparam logic [PMR_CNT_WIDTH-1:0] C_CNT_LOAD =
        (WAIT_CYCLES > 0) ? PMR_CNT_WIDTH'(WAIT_CYCLES - 1) : '0;

    pmr_state_e               r_state, w_state_nxt;
    logic [PMR_CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                     w_gnt;
    logic                     w_misalign;
    logic                     r_rvalid;
    logic                     r_err;
    logic [DATA_WIDTH-1:0]    w_arr_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PMR_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            PMR_IDLE: begin
                if (bus.req_i && (WAIT_CYCLES != 0)) begin
                    w_state_nxt = PMR_STALL;
                    w_cnt_nxt   = C_CNT_LOAD;
                end
            end
            PMR_STALL: begin
                if (!bus.req_i) begin
                    w_state_nxt = PMR_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = PMR_IDLE;
                end
            end
            default: w_state_nxt = PMR_IDLE;
        endcase
    end

    // Grant is gated by rst_n so it reads low for the whole reset window.
    always_comb begin
        w_gnt = 1'b0;
        if (rst_n && bus.req_i) begin
            case (r_state)
                PMR_IDLE:  w_gnt = (WAIT_CYCLES == 0);
                PMR_STALL: w_gnt = (r_cnt == '0);
                default:   w_gnt = 1'b0;
            endcase
        end
    end

`ifdef PROG_MEM_ALIGN_CHECK_EN
    assign w_misalign = pmr_misaligned(bus.addr_i[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_gnt;
            r_err    <= w_gnt & w_misalign;
        end
    end

    prog_mem_array #(
        .ADDR_WIDTH (WORD_AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_re    (w_gnt & ~w_misalign),
        .i_raddr (bus.addr_i[MEM_ADDR_WIDTH-1:2]),
        .o_rdata (w_arr_rdata),
        .i_we    (bus.we_i),
        .i_waddr (bus.waddr_i[MEM_ADDR_WIDTH-1:2]),
        .i_wdata (bus.wdata_i)
    );

    assign bus.gnt_o    = w_gnt;
    assign bus.rvalid_o = r_rvalid;
    assign bus.err_o    = r_err;
    // An error response carries zero data; the array output is left stale for it.
    assign bus.rdata_o  = r_err ? '0 : w_arr_rdata;
endmodule

// File: tb/tb_prog_mem_responder.sv
// Bench for prog_mem_responder: one instance with no wait states, one with three.
// A cycle-level fetch model checks every cycle; directed steps pin literal expectations.
module tb_prog_mem_responder;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req   [2];
    logic [AW-1:0] addr  [2];
    logic          we    [2];
    logic [AW-1:0] waddr [2];
    logic [DW-1:0] wdata [2];
    logic          gnt   [2];
    logic          rvalid[2];
    logic          err   [2];
    logic [DW-1:0] rdata [2];

    prog_mem_responder_if #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
    prog_mem_responder_if #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

    assign if0.req_i = req[0];   assign if1.req_i = req[1];
    assign if0.addr_i = addr[0]; assign if1.addr_i = addr[1];
    assign if0.we_i = we[0];     assign if1.we_i = we[1];
    assign if0.waddr_i = waddr[0]; assign if1.waddr_i = waddr[1];
    assign if0.wdata_i = wdata[0]; assign if1.wdata_i = wdata[1];
    assign gnt[0] = if0.gnt_o;       assign gnt[1] = if1.gnt_o;
    assign rvalid[0] = if0.rvalid_o; assign rvalid[1] = if1.rvalid_o;
    assign err[0] = if0.err_o;       assign err[1] = if1.err_o;
    assign rdata[0] = if0.rdata_o;   assign rdata[1] = if1.rdata_o;

    prog_mem_responder #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    prog_mem_responder #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    // Model: a fetch is granted once req has been high for wait_of(i) earlier
    // consecutive cycles; the response is the word at the grant edge, error
    // with zero data when misaligned and alignment checking is built in.
    int          run    [2];
    logic        pend_v [2];
    logic        pend_e [2];
    logic [31:0] pend_d [2];
    logic [31:0] mmem   [2][256];

    initial begin
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; pend_v[i] = 1'b0; pend_e[i] = 1'b0; pend_d[i] = '0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic eg;
            logic ev;
            eg = rst_n && req[i] && (run[i] == wait_of(i));
            ev = rst_n && pend_v[i];
            check($sformatf("model_gnt%0d", i), gnt[i], eg);
            check($sformatf("model_rvalid%0d", i), rvalid[i], ev);
            if (ev || !rst_n) begin
                check($sformatf("model_rdata%0d", i), rdata[i], ev ? pend_d[i] : 32'h0);
                check($sformatf("model_err%0d", i), err[i], ev ? pend_e[i] : 1'b0);
            end
            if (!rst_n) begin
                run[i] = 0;
                pend_v[i] = 1'b0;
            end else begin
                pend_v[i] = eg;
                if (eg) begin
`ifdef PROG_MEM_ALIGN_CHECK_EN
                    pend_e[i] = (addr[i][1:0] != 2'b00);
`else
                    pend_e[i] = 1'b0;
`endif
                    pend_d[i] = pend_e[i] ? 32'h0 : mmem[i][addr[i][AW-1:2]];
                    run[i] = 0;
                end else if (req[i]) begin
                    run[i] = run[i] + 1;
                end else begin
                    run[i] = 0;
                end
            end
            if (we[i]) mmem[i][waddr[i][AW-1:2]] = wdata[i];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] pre [5];

    initial begin
        pre[0] = 32'hA000_0013; pre[1] = 32'h0050_0093; pre[2] = 32'h1111_1111;
        pre[3] = 32'h3333_3333; pre[4] = 32'h4444_4444;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; addr[i] = '0; we[i] = 1'b0; waddr[i] = '0; wdata[i] = '0;
        end
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;

        for (int w = 0; w < 5; w++) begin
            for (int i = 0; i < 2; i++) begin
                we[i] = 1'b1; waddr[i] = AW'(w * 4); wdata[i] = pre[w];
            end
            cyc();
        end
        we[0] = 1'b0; we[1] = 1'b0;
        cyc();

        // Zero-wait single fetch
        req[0] = 1'b1; addr[0] = 10'h004;
        #1 check("t1_gnt_same_cycle", gnt[0], 1'b1);
        cyc();
        req[0] = 1'b0;
        #1;
        check("t1_rvalid", rvalid[0], 1'b1);
        check("t1_rdata", rdata[0], 32'h0050_0093);
        check("t1_err", err[0], 1'b0);
        cyc();

        // Back-to-back fetches
        for (int k = 0; k < 3; k++) begin
            req[0] = 1'b1; addr[0] = AW'(k * 4);
            cyc();
            check($sformatf("b2b_rvalid%0d", k), rvalid[0], 1'b1);
            check($sformatf("b2b_rdata%0d", k), rdata[0], pre[k]);
        end
        req[0] = 1'b0;
        cyc();
        check("b2b_rvalid_end", rvalid[0], 1'b0);

        // Same-edge write and read of word 2, then re-fetch
        we[0] = 1'b1; waddr[0] = 10'h008; wdata[0] = 32'hDEAD_BEEF;
        req[0] = 1'b1; addr[0] = 10'h008;
        cyc();
        we[0] = 1'b0;
        check("rbw_old_data", rdata[0], 32'h1111_1111);
        cyc();
        req[0] = 1'b0;
        check("rbw_new_data", rdata[0], 32'hDEAD_BEEF);
        cyc();

        // Misaligned fetch
        req[0] = 1'b1; addr[0] = 10'h006;
        cyc();
        req[0] = 1'b0;
        check("mis_rvalid", rvalid[0], 1'b1);
`ifdef PROG_MEM_ALIGN_CHECK_EN
        check("mis_err", err[0], 1'b1);
        check("mis_rdata", rdata[0], 32'h0);
`else
        check("mis_err", err[0], 1'b0);
        check("mis_rdata", rdata[0], 32'h0050_0093);
`endif
        cyc();

        // Three wait states
        req[1] = 1'b1; addr[1] = 10'h010;
        for (int c = 0; c < 4; c++) begin
            #1 check($sformatf("w3_gnt_c%0d", c), gnt[1], (c == 3));
            cyc();
        end
        req[1] = 1'b0;
        check("w3_rvalid", rvalid[1], 1'b1);
        check("w3_rdata", rdata[1], 32'h4444_4444);
        cyc();

        // Request dropped in cycle 1
        req[1] = 1'b1; addr[1] = 10'h000;
        cyc();
        req[1] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1 check($sformatf("abort_gnt%0d", c), gnt[1], 1'b0);
            check($sformatf("abort_rvalid%0d", c), rvalid[1], 1'b0);
            cyc();
        end
        req[1] = 1'b1; addr[1] = 10'h00C;
        for (int c = 0; c < 4; c++) begin
            #1 check($sformatf("refetch_gnt_c%0d", c), gnt[1], (c == 3));
            cyc();
        end
        req[1] = 1'b0;
        check("refetch_rdata", rdata[1], 32'h3333_3333);
        cyc();

        // Reset while one instance is stalled and the other has a response pending
        req[1] = 1'b1; addr[1] = 10'h010;
        req[0] = 1'b1; addr[0] = 10'h000;
        cyc(); cyc();
        rst_n = 1'b0;
        #1;
        check("rst_gnt_forced", gnt[0], 1'b0);
        check("rst_drop_rvalid0", rvalid[0], 1'b0);
        check("rst_rvalid1", rvalid[1], 1'b0);
        cyc();
        rst_n = 1'b1;
        req[0] = 1'b0; req[1] = 1'b0;
        cyc();
        check("post_rst_rvalid1", rvalid[1], 1'b0);
        req[1] = 1'b1; addr[1] = 10'h004;
        for (int c = 0; c < 4; c++) begin
            #1 check($sformatf("post_rst_gnt_c%0d", c), gnt[1], (c == 3));
            cyc();
        end
        req[1] = 1'b0;
        check("post_rst_rdata", rdata[1], 32'h0050_0093);
        cyc(); cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
